cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
Sequencing controller for the 4-entry fully associative data cache sitting between the CPU memory port and main memory. It owns the tag/data/valid/LRU-counter storage and runs the lookup, fill and write-through sequence. Hit detection and victim choice come from a combinational lookup sub-module. Counters are 2-bit LRU ranks (3 = most recent, 0 = victim candidate).

Parameters:
d_width, 8, data bus width
a_width, 8, address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU request strobe, sampled only in IDLE
cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
cpu_addr  in  a_width  request address
cpu_wdata  in  d_width  write data
cpu_rdata  out  d_width  read data, valid while cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse
busy  out  1  1 in any state other than IDLE
flush  in  1  invalidate all entries; honoured only in IDLE
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  a_width  memory address
mem_wdata  out  d_width  memory write data
mem_rdata  in  d_width  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle
hit_cnt  out  8  saturating count of read hits, for debug

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all valid=0, counters=0, tags/data=0; cpu_ack=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, hit_cnt=0. Reset mid-transaction aborts it; no ack is issued.
- All outputs are registered.
- States: IDLE, LOOKUP, MEM_RD, MEM_WR, DONE.
- IDLE:
  - flush=1: clears all valid and counters in one cycle and stays in IDLE. flush has priority over a simultaneous cpu_req, which is dropped.
  - else cpu_req=1: latch addr/we/wdata and go to LOOKUP.
- LOOKUP:
  - Read hit at entry i: cpu_rdata<=data[i], then DONE. Latency is 2 cycles from the req sample to cpu_ack.
  - Read miss: mem_addr<=addr, mem_we<=0, mem_req<=1, then MEM_RD.
  - Write, hit or miss: write-through. mem_we<=1, mem_wdata<=wdata, mem_req<=1, then MEM_WR.
  - Write hit updates data[i] in LOOKUP. Write miss does not allocate.
- MEM_RD: hold mem_req until mem_ack. On mem_ack:
  - fill the victim with tag=addr, data=mem_rdata, valid=1;
  - cpu_rdata<=mem_rdata; drop mem_req; go to DONE.
- MEM_WR: hold until mem_ack, drop mem_req, go to DONE.
- mem_ack is accepted in the first cycle mem_req is high. mem_ack in any other state is ignored.
- DONE: cpu_ack=1 for exactly one cycle, then IDLE. cpu_req is ignored outside IDLE.
- Victim choice: lowest index with valid=0 or cnt=0; otherwise entry 3.
- LRU update on hit at i (read or write):
  - every valid j≠i with cnt[j] > cnt[i] decrements;
  - cnt[i]<=3.
- LRU update on fill of victim v: every valid j≠v with cnt[j]>0 decrements; cnt[v]<=3.
- Counters never wrap below 0. Invalid entries' counters stay 0.
- hit_cnt increments on each read hit and saturates at 255.
- Duplicate tags cannot arise, because write miss never allocates.

Decomposition:
- Shared package: state enum (IDLE, LOOKUP, MEM_RD, MEM_WR, DONE), CNT_MRU=2'b11, NUM_ENTRIES=4, 2-bit counter typedef.
- Sub-module cache_lookup, combinational:
  - inputs: addr, tags, valid, cnt;
  - outputs: hit, hit_idx, victim_idx, next-counter vector.
  - It is instantiated once in cache_ctrl.
- cache_ctrl holds the FSM, storage and memory handshake.

Test Plan:
- Read 0x10 after reset, mem returns 0xAB after 3 cycles -> one MEM_RD with mem_addr=0x10; entry0 valid, cnt0=3; cpu_ack with cpu_rdata=0xAB; re-read 0x10 acks at cycle 2 with no mem_req, hit_cnt=1.
- Read misses 0x01, 0x02, 0x03, 0x04 (fill), then read 0x01 (hit), then miss 0x05 -> 0x05 replaces entry1 (addr 0x02). Counters before the 0x05 fill are 3,0,1,2.
- Write 0x03 data 0x5A on hit -> entry updated; mem_req=1, mem_we=1, mem_wdata=0x5A held until ack. Write miss 0x77 -> memory write only, no entry allocated.
- flush and cpu_req asserted together in IDLE -> all valid=0, no ack, busy stays 0; the next read of a previously cached address misses.
- Assert rst_n=0 while in MEM_RD -> mem_req drops immediately, no cpu_ack, all entries invalid; a later mem_ack is ignored.
- mem_ack arrives in the same cycle mem_req rises, and cpu_req is held high throughout -> transaction completes; a new request is accepted only in the IDLE cycle after DONE.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared types and constants for the 4-entry cache controller
package cache_ctrl_pkg;

    localparam int NUM_ENTRIES = 4;
    localparam int IDX_W       = 2;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_MRU = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        MEM_WR,
        DONE
    } state_t;

endpackage

// File: rtl/cache_ctrl_lookup.sv
// rtl/cache_ctrl_lookup.sv - combinational hit detect, victim select and LRU rank update
module cache_lookup
    import cache_ctrl_pkg::*;
#(
    parameter int a_width = 8
) (
    input  logic [a_width-1:0]     addr,
    input  logic [a_width-1:0]     tags [NUM_ENTRIES],
    input  logic [NUM_ENTRIES-1:0] valid,
    input  cnt_t                   cnt [NUM_ENTRIES],
    output logic                   hit,
    output logic [IDX_W-1:0]       hit_idx,
    output logic [IDX_W-1:0]       victim_idx,
    output cnt_t                   cnt_nxt [NUM_ENTRIES]
);

    logic             found;
    logic [IDX_W-1:0] sel_idx;

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        found      = 1'b0;
        victim_idx = IDX_W'(NUM_ENTRIES - 1);
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!hit && valid[i] && (tags[i] == addr)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!found && (!valid[i] || (cnt[i] == 2'd0))) begin
                found      = 1'b1;
                victim_idx = IDX_W'(i);
            end
        end
    end

    // A hit only ages entries ranked above the touched one; a fill ages every non-zero rank.
    always_comb begin
        sel_idx = hit ? hit_idx : victim_idx;
        for (int j = 0; j < NUM_ENTRIES; j++) begin
            cnt_nxt[j] = cnt[j];
            if (IDX_W'(j) == sel_idx) begin
                cnt_nxt[j] = CNT_MRU;
            end else if (valid[j]) begin
                if (hit && (cnt[j] > cnt[hit_idx])) begin
                    cnt_nxt[j] = cnt[j] - 2'd1;
                end else if (!hit && (cnt[j] != 2'd0)) begin
                    cnt_nxt[j] = cnt[j] - 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - 4-entry fully associative write-through cache sequencer
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int d_width = 8,
    parameter int a_width = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [a_width-1:0] cpu_addr,
    input  logic [d_width-1:0] cpu_wdata,
    output logic [d_width-1:0] cpu_rdata,
    output logic               cpu_ack,
    output logic               busy,
    input  logic               flush,
    output logic               mem_req,
    output logic               mem_we,
    output logic [a_width-1:0] mem_addr,
    output logic [d_width-1:0] mem_wdata,
    input  logic [d_width-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic [7:0]         hit_cnt
);

    state_t                   state_q, state_d;
    logic [a_width-1:0]       addr_q, addr_d;
    logic                     we_q, we_d;
    logic [d_width-1:0]       wdata_q, wdata_d;
    logic [a_width-1:0]       tags_q [NUM_ENTRIES];
    logic [a_width-1:0]       tags_d [NUM_ENTRIES];
    logic [d_width-1:0]       data_q [NUM_ENTRIES];
    logic [d_width-1:0]       data_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]   valid_q, valid_d;
    cnt_t                     cnt_q [NUM_ENTRIES];
    cnt_t                     cnt_d [NUM_ENTRIES];
    logic [d_width-1:0]       cpu_rdata_q, cpu_rdata_d;
    logic                     cpu_ack_q, cpu_ack_d;
    logic                     busy_q, busy_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_we_q, mem_we_d;
    logic [a_width-1:0]       mem_addr_q, mem_addr_d;
    logic [d_width-1:0]       mem_wdata_q, mem_wdata_d;
    logic [7:0]               hit_cnt_q, hit_cnt_d;

    logic                     lk_hit;
    logic [IDX_W-1:0]         lk_hit_idx;
    logic [IDX_W-1:0]         lk_victim_idx;
    cnt_t                     lk_cnt_nxt [NUM_ENTRIES];

    cache_lookup #(
        .a_width (a_width)
    ) u_lookup (
        .addr       (addr_q),
        .tags       (tags_q),
        .valid      (valid_q),
        .cnt        (cnt_q),
        .hit        (lk_hit),
        .hit_idx    (lk_hit_idx),
        .victim_idx (lk_victim_idx),
        .cnt_nxt    (lk_cnt_nxt)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        tags_d      = tags_q;
        data_d      = data_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                    for (int i = 0; i < NUM_ENTRIES; i++) begin
                        cnt_d[i] = '0;
                    end
                end else if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (we_q) begin
                    // Write-through: memory is always written, the cache only if it already holds the line.
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    state_d     = MEM_WR;
                    if (lk_hit) begin
                        data_d[lk_hit_idx] = wdata_q;
                        cnt_d              = lk_cnt_nxt;
                    end
                end else if (lk_hit) begin
                    cpu_rdata_d = data_q[lk_hit_idx];
                    cnt_d       = lk_cnt_nxt;
                    if (hit_cnt_q != 8'hFF) begin
                        hit_cnt_d = hit_cnt_q + 8'd1;
                    end
                    state_d = DONE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                    state_d    = MEM_RD;
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    tags_d[lk_victim_idx]  = addr_q;
                    data_d[lk_victim_idx]  = mem_rdata;
                    valid_d[lk_victim_idx] = 1'b1;
                    cnt_d                  = lk_cnt_nxt;
                    cpu_rdata_d            = mem_rdata;
                    mem_req_d              = 1'b0;
                    state_d                = DONE;
                end
            end
            MEM_WR: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered, so they are derived from the state being entered.
        cpu_ack_d = (state_d == DONE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            valid_q     <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tags_q[i] <= '0;
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            valid_q     <= valid_d;
            tags_q      <= tags_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - self-checking bench for cache_ctrl against a behavioural cache model
module tb_cache_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_req, cpu_we, flush, mem_ack;
    logic [7:0] cpu_addr, cpu_wdata, mem_rdata;
    logic [7:0] cpu_rdata, mem_addr, mem_wdata, hit_cnt;
    logic       cpu_ack, busy, mem_req, mem_we;

    int n_cmp  = 0;
    int n_fail = 0;

    cache_ctrl #(.d_width(8), .a_width(8)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .busy(busy), .flush(flush), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: main memory plus the cache contents and LRU ranks as plain arrays.
    logic [7:0] mem [256];
    bit         m_valid [4];
    int         m_tag [4];
    int         m_data [4];
    int         m_cnt [4];
    int         m_hits;

    function automatic void model_flush();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = 0;
        end
    endfunction

    function automatic void model_reset();
        model_flush();
        m_hits = 0;
    endfunction

    function automatic void model_touch(int i);
        for (int j = 0; j < 4; j++)
            if (j != i && m_valid[j] && m_cnt[j] > m_cnt[i]) m_cnt[j]--;
        m_cnt[i] = 3;
    endfunction

    function automatic void model_access(input logic we, input logic [7:0] a, input logic [7:0] wd,
                                         output bit hit, output logic [7:0] rd);
        int idx, v;
        idx = -1;
        for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == int'(a)) idx = i;
        hit = (idx >= 0);
        rd  = '0;
        if (we) begin
            mem[a] = wd;
            if (hit) begin
                m_data[idx] = int'(wd);
                model_touch(idx);
            end
        end else if (hit) begin
            rd = 8'(m_data[idx]);
            model_touch(idx);
            if (m_hits < 255) m_hits++;
        end else begin
            rd = mem[a];
            v  = 3;
            for (int i = 3; i >= 0; i--) if (!m_valid[i] || m_cnt[i] == 0) v = i;
            for (int j = 0; j < 4; j++)
                if (j != v && m_valid[j] && m_cnt[j] > 0) m_cnt[j]--;
            m_cnt[v] = 3; m_valid[v] = 1; m_tag[v] = int'(a); m_data[v] = int'(rd);
        end
    endfunction

    // Issues one CPU request and acts as main memory; returns what was observed.
    task automatic drive_access(input logic we, input logic [7:0] a, input logic [7:0] wd,
                                input int dly, input bit hold,
                                output bit done, output int lat, output int nreq, output int reqcyc,
                                output logic [7:0] rd, output logic [7:0] maddr,
                                output logic mwe, output logic [7:0] mwd);
        int wait_c;
        bit prev;
        done = 0; lat = 0; nreq = 0; reqcyc = 0; rd = '0; maddr = '0; mwe = 0; mwd = '0;
        wait_c = 0; prev = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            lat++;
            if (!hold) cpu_req = 1'b0;
            mem_ack = 1'b0;
            if (cpu_ack) begin
                done = 1;
                rd   = cpu_rdata;
            end else if (mem_req) begin
                reqcyc++;
                if (!prev) begin
                    nreq++; maddr = mem_addr; mwe = mem_we; mwd = mem_wdata; wait_c = 0;
                end
                if (wait_c == dly) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else mem_rdata = mem[mem_addr];
                end
                wait_c++;
            end
            prev = mem_req;
        end
        if (!hold) cpu_req = 1'b0;
        mem_ack = 1'b0;
    endtask

    bit         done, ehit;
    int         lat, nreq, reqcyc;
    logic [7:0] rd, maddr, mwd, erd;
    logic       mwe;

    task automatic test_reset();
        rst_n = 1'b0; cpu_req = 0; cpu_we = 0; flush = 0; mem_ack = 0;
        cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if ({cpu_ack, busy, mem_req, mem_we} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {cpu_ack, busy, mem_req, mem_we});
        end
        n_cmp++; if ({cpu_rdata, mem_addr, mem_wdata, hit_cnt} !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {cpu_rdata, mem_addr, mem_wdata, hit_cnt});
        end
        n_cmp++; if (dut.valid_q !== 4'b0000) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0000", dut.valid_q);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_read();
        mem[8'h10] = 8'hAB;
        drive_access(0, 8'h10, 8'h00, 3, 0, done, lat, nreq, reqcyc, rd, maddr, mwe, mwd);
        model_access(0, 8'h10, 8'h00, ehit, erd);
        n_cmp++; if (!done || rd !== 8'hAB) begin
            n_fail++; $display("FAIL miss_rdata: got %h done=%0d expected ab", rd, done);
        end
        n_cmp++; if (nreq !== 1 || maddr !== 8'h10 || mwe !== 1'b0) begin
            n_fail++; $display("FAIL miss_memreq: got n=%0d addr=%h we=%b expected 1/10/0", nreq, maddr, mwe);
        end
        n_cmp++; if (lat !== 6) begin
            n_fail++; $display("FAIL miss_latency: got %0d expected 6", lat);
        end
        n_cmp++; if (dut.valid_q[0] !== 1'b1 || dut.cnt_q[0] !== 2'd3) begin
            n_fail++; $display("FAIL fill_entry0: got v=%b c=%0d expected 1/3", dut.valid_q[0], dut.cnt_q[0]);
        end
        drive_access(0, 8'h10, 8'h00, 0, 0, done, lat, nreq, reqcyc, rd, maddr, mwe, mwd);
        model_access(0, 8'h10, 8'h00, ehit, erd);
        n_cmp++; if (!done || lat !== 2 || nreq !== 0 || rd !== 8'hAB) begin
            n_fail++; $display("FAIL hit_read: got lat=%0d n=%0d rd=%h expected 2/0/ab", lat, nreq, rd);
        end
        n_cmp++; if (hit_cnt !== 8'd1) begin
            n_fail++; $display("FAIL hit_cnt_one: got %0d expected 1", hit_cnt);
        end
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_flush();
    endtask

    task automatic test_lru();
        logic [7:0] seq [5];
        int         exp_cnt [4];
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01};
        exp_cnt = '{3, 0, 1, 2};
        do_flush();
        foreach (seq[k]) begin
            drive_access(0, seq[k], 8'h00, $urandom_range(0, 2), 0, done, lat, nreq, reqcyc, rd, maddr, mwe, mwd);
            model_access(0, seq[k], 8'h00, ehit, erd);
            n_cmp++; if (!done || rd !== erd) begin
                n_fail++; $display("FAIL lru_fill_rd %h: got %h expected %h", seq[k], rd, erd);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (dut.cnt_q[i] !== 2'(exp_cnt[i]) || m_cnt[i] != exp_cnt[i]) begin
                n_fail++; $display("FAIL lru_rank%0d: got %0d expected %0d", i, dut.cnt_q[i], exp_cnt[i]);
            end
        end
        drive_access(0, 8'h05, 8'h00, 1, 0, done, lat, nreq, reqcyc, rd, maddr, mwe, mwd);
        model_access(0, 8'h05, 8'h00, ehit, erd);
        n_cmp++; if (dut.tags_q[1] !== 8'h05 || dut.tags_q[0] !== 8'h01 || nreq !== 1) begin
            n_fail++; $display("FAIL lru_victim: got tag1=%h tag0=%h expected 05/01", dut.tags_q[1], dut.tags_q[0]);
        end
    endtask

    task automatic test_write();
        drive_access(1, 8'h03, 8'h5A, 2, 0, done, lat, nreq, reqcyc, rd, maddr, mwe, mwd);
        model_access(1, 8'h03, 8'h5A, ehit, erd);
        n_cmp++; if (!done || nreq !== 1 || maddr !== 8'h03 || mwe !== 1'b1 || mwd !== 8'h5A) begin
            n_fail++; $display("FAIL write_hit_mem: got n=%0d a=%h we=%b d=%h expected 1/03/1/5a", nreq, maddr, mwe, mwd);
        end
        n_cmp++; if (reqcyc !== 3 || lat !== 5) begin
            n_fail++; $display("FAIL write_hold: got req_cycles=%0d lat=%0d expected 3/5", reqcyc, lat);
        end
        n_cmp++; if (dut.data_q[2] !== 8'h5A || dut.cnt_q[2] !== 2'd3) begin
            n_fail++; $display("FAIL write_hit_entry: got %h/%0d expected 5a/3", dut.data_q[2], dut.cnt_q[2]);
        end
        drive_access(1, 8'h77, 8'hC3, 1, 0, done, lat, nreq, reqcyc, rd, maddr, mwe, mwd);
        model_access(1, 8'h77, 8'hC3, ehit, erd);
        n_cmp++; if (!done || nreq !== 1 || mwd !== 8'hC3 || maddr !== 8'h77) begin
            n_fail++; $display("FAIL write_miss_mem: got n=%0d a=%h d=%h expected 1/77/c3", nreq, maddr, mwd);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (dut.tags_q[i] === 8'h77 && dut.valid_q[i]) begin
                n_fail++; $display("FAIL write_miss_alloc: got entry%0d=77 expected no allocation", i);
            end
        end
        drive_access(0, 8'h77, 8'h00, 0, 0, done, lat, nreq, reqcyc, rd, maddr, mwe, mwd);
        model_access(0, 8'h77, 8'h00, ehit, erd);
        n_cmp++; if (nreq !== 1 || rd !== 8'hC3) begin
            n_fail++; $display("FAIL write_miss_readback: got n=%0d rd=%h expected 1/c3", nreq, rd);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
        @(negedge clk);
        flush = 1'b0; cpu_req = 1'b0;
        model_flush();
        n_cmp++; if (dut.valid_q !== 4'b0000) begin
            n_fail++; $display("FAIL flush_valid: got %b expected 0000", dut.valid_q);
        end
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (busy !== 1'b0 || cpu_ack !== 1'b0) begin
                n_fail++; $display("FAIL flush_idle: got busy=%b ack=%b expected 0/0", busy, cpu_ack);
            end
            @(negedge clk);
        end
        drive_access(0, 8'h01, 8'h00, 0, 0, done, lat, nreq, reqcyc, rd, maddr, mwe, mwd);
        model_access(0, 8'h01, 8'h00, ehit, erd);
        n_cmp++; if (nreq !== 1 || rd !== erd || ehit) begin
            n_fail++; $display("FAIL flush_remiss: got n=%0d rd=%h expected 1/%h", nreq, rd, erd);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            seen = mem_req;
        end
        n_cmp++; if (!seen) begin
            n_fail++; $display("FAIL rst_mid_reach: got no mem_req expected mem_req within 10 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++; if ({mem_req, cpu_ack, busy} !== 3'b000 || dut.valid_q !== 4'b0000) begin
            n_fail++; $display("FAIL rst_mid_abort: got req/ack/busy=%b valid=%b expected 000/0000",
                               {mem_req, cpu_ack, busy}, dut.valid_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if ({mem_req, cpu_ack, busy} !== 3'b000 || hit_cnt !== 8'd0) begin
                n_fail++; $display("FAIL rst_mid_stray_ack: got req/ack/busy=%b hit=%0d expected 000/0",
                                   {mem_req, cpu_ack, busy}, hit_cnt);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        bit fin;
        fin = 0;
        drive_access(0, 8'h30, 8'h00, 0, 1, done, lat, nreq, reqcyc, rd, maddr, mwe, mwd);
        model_access(0, 8'h30, 8'h00, ehit, erd);
        n_cmp++; if (!done || lat !== 3 || rd !== erd) begin
            n_fail++; $display("FAIL b2b_first: got lat=%0d rd=%h expected 3/%h", lat, rd, erd);
        end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || cpu_ack !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle_gap: got busy=%b ack=%b expected 0/0", busy, cpu_ack);
        end
        @(negedge clk);
        cpu_req = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_accept: got busy=%b expected 1", busy);
        end
        model_access(0, 8'h30, 8'h00, ehit, erd);
        for (int c = 0; c < 10 && !fin; c++) begin
            @(negedge clk);
            if (cpu_ack) fin = 1;
        end
        n_cmp++; if (!fin || cpu_rdata !== erd || hit_cnt !== 8'(m_hits)) begin
            n_fail++; $display("FAIL b2b_second: got ack=%0d rd=%h hits=%0d expected 1/%h/%0d",
                               fin, cpu_rdata, hit_cnt, erd, m_hits);
        end
    endtask

    task automatic test_random();
        logic       we;
        logic [7:0] a, wd;
        int         dly;
        for (int n = 0; n < 60; n++) begin
            we  = ($urandom_range(0, 9) < 3);
            a   = 8'h40 + 8'($urandom_range(0, 7));
            wd  = 8'($urandom);
            dly = $urandom_range(0, 3);
            drive_access(we, a, wd, dly, 0, done, lat, nreq, reqcyc, rd, maddr, mwe, mwd);
            model_access(we, a, wd, ehit, erd);
            n_cmp++; if (!done || lat !== ((!we && ehit) ? 2 : 3 + dly) || nreq !== ((!we && ehit) ? 0 : 1)) begin
                n_fail++; $display("FAIL rand_timing #%0d: got done=%0d lat=%0d n=%0d we=%b hit=%0d dly=%0d",
                                   n, done, lat, nreq, we, ehit, dly);
            end
            n_cmp++; if ((!we && rd !== erd) || (nreq == 1 && (maddr !== a || mwe !== we || (we && mwd !== wd)))) begin
                n_fail++; $display("FAIL rand_data #%0d: got rd=%h a=%h we=%b d=%h expected rd=%h a=%h we=%b d=%h",
                                   n, rd, maddr, mwe, mwd, erd, a, we, wd);
            end
            n_cmp++; if (hit_cnt !== 8'(m_hits)) begin
                n_fail++; $display("FAIL rand_hit_cnt #%0d: got %0d expected %0d", n, hit_cnt, m_hits);
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (dut.valid_q[i] !== m_valid[i] || dut.cnt_q[i] !== 2'(m_cnt[i])) begin
                    n_fail++; $display("FAIL rand_entry%0d #%0d: got v=%b c=%0d expected v=%0d c=%0d",
                                       i, n, dut.valid_q[i], dut.cnt_q[i], m_valid[i], m_cnt[i]);
                end
            end
        end
    endtask

    task automatic test_hit_saturate();
        drive_access(0, 8'h30, 8'h00, 0, 0, done, lat, nreq, reqcyc, rd, maddr, mwe, mwd);
        model_access(0, 8'h30, 8'h00, ehit, erd);
        for (int n = 0; n < 260; n++) begin
            drive_access(0, 8'h30, 8'h00, 0, 0, done, lat, nreq, reqcyc, rd, maddr, mwe, mwd);
            model_access(0, 8'h30, 8'h00, ehit, erd);
        end
        n_cmp++; if (hit_cnt !== 8'd255 || m_hits != 255) begin
            n_fail++; $display("FAIL hit_cnt_saturate: got %0d expected 255", hit_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_first_read();
        test_lru();
        test_write();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_hit_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
